counter_0_to_9: RTL and testbench



---
 rtl/counter_0_to_9.sv | 42 ++++
 tb/tb_counter_0_to_9.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/counter_0_to_9.sv
// Decade up-counter with count enable and terminal-count flag.
// Wraps MAX_COUNT -> 0; out-of-range values reload 0 on the next enabled edge.
module counter_0_to_9 #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // >= also catches upset values above MAX_COUNT
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (cnt_q >= MaxVal) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = en & (cnt_q == MaxVal);

endmodule

// File: tb/tb_counter_0_to_9.sv
// Scoreboard bench for counter_0_to_9: driver pushes expected tc/cnt,
// monitor pops and compares against the DUT.
module tb_counter_0_to_9;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] cnt;
    logic       tc;

    int checks;
    int passes;
    int tc_seen;
    int model_cnt;

    int exp_tc_q[$];
    int exp_cnt_q[$];

    counter_0_to_9 #(.WIDTH(4), .MAX_COUNT(9)) dut (
        .clk(clk),
        .rst(rst),
        .en (en),
        .cnt(cnt),
        .tc (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: decade counter in plain integer arithmetic
    function automatic int next_count(input int c, input logic r, input logic e);
        if (r === 1'b1) return 0;
        if (e !== 1'b1) return c;
        if (c > 9) return 0;
        return (c + 1) % 10;
    endfunction

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        en  = e;
        exp_tc_q.push_back(((e === 1'b1) && (model_cnt == 9)) ? 1 : 0);
        model_cnt = next_count(model_cnt, r, e);
        exp_cnt_q.push_back(model_cnt);
    endtask

    task automatic deposit_step(input logic [3:0] v);
        @(negedge clk);
        dut.cnt_q <= v;
        rst = 1'b0;
        en  = 1'b1;
        model_cnt = int'(v);
        exp_tc_q.push_back((model_cnt == 9) ? 1 : 0);
        model_cnt = next_count(model_cnt, 1'b0, 1'b1);
        exp_cnt_q.push_back(model_cnt);
    endtask

    // Monitor: tc after inputs settle, cnt just after the edge
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (exp_tc_q.size() > 0) begin
                if (tc === 1'b1) tc_seen++;
                check("tc", int'(tc), exp_tc_q.pop_front());
            end
            @(posedge clk);
            #1;
            if (exp_cnt_q.size() > 0) begin
                check("cnt", int'(cnt), exp_cnt_q.pop_front());
            end
        end
    end

    initial begin
        int base;
        checks    = 0;
        passes    = 0;
        tc_seen   = 0;
        model_cnt = 0;
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);

        // reset held with en low, high and unknown
        repeat (5) step(1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'bx);

        // free count through a wrap
        repeat (12) step(1'b0, 1'b1);

        // hold at 5, then resume
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // reset beats enable at 7
        step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);

        // wrap stress: 100 enabled edges from 0
        step(1'b1, 1'b0);
        #4;
        base = tc_seen;
        repeat (100) step(1'b0, 1'b1);
        #4;
        check("tc_pulses_100", tc_seen - base, 10);

        // randomized enable with occasional reset
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        // out-of-range recovery
        step(1'b0, 1'b0);
        deposit_step(4'd12);
        repeat (3) step(1'b0, 1'b1);
        deposit_step(4'd15);
        repeat (2) step(1'b0, 1'b1);

        @(negedge clk);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("tc_queue_drained", exp_tc_q.size(), 0);
        check("cnt_queue_drained", exp_cnt_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
